// File: rtl/axis_pkt_mux_pkg.sv
// ============================================================================
// Module      : axis_pkt_mux_pkg
// Description : Shared FSM states, skid-buffer depth and the round-robin
//               next-grant helper for the AXI-Stream packet multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkt_mux_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int MAX_CH     = 16;

    // Returns the first valid channel after cur, scanning upward with wrap.
    // Returns cur when no other channel is valid.
    function automatic int rr_next_grant(
        input logic [MAX_CH-1:0] valid,
        input int                cur,
        input int                n_ch
    );
        int idx;
        rr_next_grant = cur;
        for (int i = MAX_CH - 1; i >= 1; i--) begin
            idx = (cur + i) % n_ch;
            if ((i < n_ch) && valid[idx]) begin
                rr_next_grant = idx;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_buf.sv
// ============================================================================
// Module      : axis_skid_buf
// Description : Two-entry skid buffer with a registered upstream ready, so
//               the input ready never depends combinationally on out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_skid_buf
    import axis_pkt_mux_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             not_empty
);

    localparam logic [1:0] FULL = 2'(SKID_DEPTH);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             out_v_q;
    logic             out_v_d;
    logic             skid_v_q;
    logic             skid_v_d;
    logic             ready_q;
    logic             in_fire;
    logic [1:0]       occ_d;

    always_comb begin
        in_fire  = in_valid & ready_q;
        out_d    = out_q;
        skid_d   = skid_q;
        out_v_d  = out_v_q;
        skid_v_d = skid_v_q;
        if (skid_v_q) begin
            if (out_ready) begin
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
            end
        end else if (!out_v_q || out_ready) begin
            out_v_d = in_fire;
            if (in_fire) begin
                out_d = in_data;
            end
        end else if (in_fire) begin
            skid_d   = in_data;
            skid_v_d = 1'b1;
        end
        occ_d = {1'b0, out_v_d} + {1'b0, skid_v_d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            out_q    <= out_d;
            skid_q   <= skid_d;
            out_v_q  <= out_v_d;
            skid_v_q <= skid_v_d;
            ready_q  <= (occ_d < FULL);
        end
    end

    assign in_ready  = ready_q;
    assign out_data  = out_q;
    assign out_valid = out_v_q;
    assign not_empty = out_v_q | skid_v_q;

endmodule

`default_nettype wire

// File: rtl/axis_pkt_mux.sv
// ============================================================================
// Module      : axis_pkt_mux
// Description : N-channel AXI-Stream packet multiplexer; grant frozen for a
//               whole packet. Define AXIS_PKT_MUX_RR_EN for round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pkt_mux
    import axis_pkt_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       s_axis_tvalid,
    output logic [N_CH-1:0]       s_axis_tready,
    input  logic [N_CH*WIDTH-1:0] s_axis_tdata,
    input  logic [N_CH-1:0]       s_axis_tlast,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  rr_mode,
    output logic [WIDTH-1:0]      m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  busy
);

    localparam int               GRANT_SPAN = 1 << SEL_W;
    localparam logic [SEL_W:0]   CH_LIMIT   = (SEL_W+1)'(N_CH);

    state_t                  state_q;
    state_t                  state_d;
    logic [SEL_W-1:0]        grant_q;
    logic [SEL_W-1:0]        grant_d;
    logic [SEL_W-1:0]        idle_grant;
    logic [GRANT_SPAN-1:0]   valid_ext;
    logic [GRANT_SPAN-1:0]   last_ext;
    logic [WIDTH-1:0]        cur_data;
    logic                    in_range;
    logic                    cur_valid;
    logic                    cur_last;
    logic                    buf_ready;
    logic                    buf_not_empty;
    logic                    accept;
    logic [WIDTH:0]          buf_out;

    // Pad per-channel flags to the full select span so any grant value indexes safely.
    always_comb begin
        valid_ext           = '0;
        last_ext            = '0;
        valid_ext[N_CH-1:0] = s_axis_tvalid;
        last_ext[N_CH-1:0]  = s_axis_tlast;
    end

    always_comb begin
        cur_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_q == SEL_W'(k)) begin
                cur_data = s_axis_tdata[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_range  = ({1'b0, grant_q} < CH_LIMIT);
    assign cur_valid = in_range & valid_ext[grant_q];
    assign cur_last  = last_ext[grant_q];
    assign accept    = cur_valid & buf_ready;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_tready
            assign s_axis_tready[k] = buf_ready & (grant_q == SEL_W'(k));
        end
    endgenerate

`ifdef AXIS_PKT_MUX_RR_EN
    logic [MAX_CH-1:0] rr_valid;

    always_comb begin
        rr_valid           = '0;
        rr_valid[N_CH-1:0] = s_axis_tvalid;
        if (rr_mode) begin
            idle_grant = SEL_W'(rr_next_grant(rr_valid, int'(grant_q), N_CH));
        end else begin
            idle_grant = sel_in;
        end
    end
`else
    logic unused_rr_mode;
    assign unused_rr_mode = rr_mode;
    assign idle_grant     = sel_in;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (accept && !cur_last) begin
                    state_d = PKT;
                end else begin
                    grant_d = idle_grant;
                end
            end
            PKT: begin
                if (accept && cur_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    axis_skid_buf #(
        .WIDTH (WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   ({cur_last, cur_data}),
        .in_valid  (cur_valid),
        .in_ready  (buf_ready),
        .out_data  (buf_out),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .not_empty (buf_not_empty)
    );

    assign m_axis_tdata = buf_out[WIDTH-1:0];
    assign m_axis_tlast = buf_out[WIDTH];
    assign cur_sel      = grant_q;
    assign busy         = (state_q == PKT) | buf_not_empty;

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_mux.sv
// ============================================================================
// Module      : tb_axis_pkt_mux
// Description : Directed scoreboard bench for axis_pkt_mux (4-channel main
//               instance plus a 3-channel instance for out-of-range select).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_pkt_mux;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*W-1:0]  s_tdata;
    logic [N-1:0]    s_tlast;
    logic [SW-1:0]   sel_in;
    logic            rr_mode;
    logic [W-1:0]    m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic [SW-1:0]   cur_sel;
    logic            busy;

    logic [2:0]      v3;
    logic [2:0]      tready3;
    logic [3*W-1:0]  data3;
    logic [2:0]      last3;
    logic [1:0]      sel3;
    logic [W-1:0]    mdata3;
    logic            mvalid3;
    logic            mlast3;
    logic [1:0]      cur3;
    logic            busy3;

    int              checks = 0;
    int              errors = 0;
    logic [W:0]      exp_q[$];
    logic            hold_pend = 1'b0;
    logic [W:0]      hold_val  = '0;
    logic            bp_done;
    logic [5:0]      bp_pat = 6'b101001;

    always #5 clk = ~clk;

    axis_pkt_mux #(.WIDTH(W), .N_CH(N), .SEL_W(SW)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .sel_in(sel_in), .rr_mode(rr_mode),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .cur_sel(cur_sel), .busy(busy)
    );

    axis_pkt_mux #(.WIDTH(W), .N_CH(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(v3), .s_axis_tready(tready3),
        .s_axis_tdata(data3), .s_axis_tlast(last3),
        .sel_in(sel3), .rr_mode(1'b0),
        .m_axis_tdata(mdata3), .m_axis_tvalid(mvalid3),
        .m_axis_tlast(mlast3), .m_axis_tready(1'b1),
        .cur_sel(cur3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), W'(base + i + 1)});
        end
    endtask

    task automatic send_beat(input int ch, input logic [W-1:0] d, input logic l);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        s_tvalid[ch]        = 1'b1;
        s_tdata[ch*W +: W]  = d;
        s_tlast[ch]         = l;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = s_tready[ch] && !reset;
            @(posedge clk);
            #1;
            t++;
        end
        check("tx_accept", 32'(acc), 1);
        s_tvalid[ch] = 1'b0;
        s_tlast[ch]  = 1'b0;
    endtask

    task automatic send_pkt(input int ch, input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            send_beat(ch, W'(base + i + 1), (i == n - 1));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 0);
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_stable", {m_tvalid, m_tlast, m_tdata}, {1'b1, hold_val});
            end
            if (m_tvalid && m_tready) begin
                check("unexpected_beat", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("out_beat", {m_tlast, m_tdata}, exp_q.pop_front());
                end
            end
            hold_pend <= m_tvalid && !m_tready;
            hold_val  <= {m_tlast, m_tdata};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        sel_in   = '0;
        rr_mode  = 1'b0;
        m_tready = 1'b1;
        v3       = 3'b111;
        data3    = {16'h3333, 16'h2222, 16'h1111};
        last3    = 3'b000;
        sel3     = 2'd3;
        bp_done  = 1'b0;
        #2;
        check("rst_mvalid", 32'(m_tvalid), 0);
        check("rst_mlast",  32'(m_tlast), 0);
        check("rst_mdata",  32'(m_tdata), 0);
        check("rst_tready", 32'(s_tready), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_cursel", 32'(cur_sel), 0);

`ifdef AXIS_PKT_MUX_RR_EN
        rr_mode = 1'b1;
        push_pkt(16'h1100, 2);
        push_pkt(16'h3300, 2);
        push_pkt(16'h0500, 2);
        fork
            send_pkt(0, 2, 16'h0500);
            send_pkt(1, 2, 16'h1100);
            send_pkt(3, 2, 16'h3300);
            begin
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(posedge clk);
                #1;
                check("tready_after_rst", 32'(s_tready[cur_sel]), 1);
            end
        join
        drain();
        rr_mode = 1'b0;
`else
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("tready_after_rst", 32'(s_tready[cur_sel]), 1);
`endif

        // Fixed mode, ch2: first output two cycles after sel_in, then back-to-back.
        sel_in = 2'd2;
        push_pkt(16'h00A0, 4);
        fork
            send_pkt(2, 4, 16'h00A0);
            begin
                @(posedge clk);
                #1;
                check("lat_no_early_valid", 32'(m_tvalid), 0);
                @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) begin
                    check("fixed_beat", {m_tvalid, m_tlast, m_tdata}, {1'b1, (i == 3), 16'(16'hA1 + i)});
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();

        // Select changes mid-packet: ch1 completes before ch3 is granted.
        sel_in = 2'd1;
        @(posedge clk);
        #1;
        push_pkt(16'h00B0, 5);
        push_pkt(16'h00C0, 2);
        send_beat(1, 16'h00B1, 1'b0);
        send_beat(1, 16'h00B2, 1'b0);
        sel_in = 2'd3;
        fork
            send_pkt(3, 2, 16'h00C0);
            begin
                send_beat(1, 16'h00B3, 1'b0);
                send_beat(1, 16'h00B4, 1'b0);
                check("grant_frozen", 32'(cur_sel), 1);
                send_beat(1, 16'h00B5, 1'b1);
            end
        join
        drain();
        check("cursel_switched", 32'(cur_sel), 3);

        // Backpressure 1,0,0,1,0,1 repeating during an 8-beat packet.
        sel_in = 2'd0;
        @(posedge clk);
        #1;
        push_pkt(16'h00E0, 8);
        bp_done = 1'b0;
        fork
            begin
                send_pkt(0, 8, 16'h00E0);
                bp_done = 1'b1;
            end
            begin
                int bi;
                bi = 0;
                while (!bp_done) begin
                    m_tready = bp_pat[bi % 6];
                    bi++;
                    @(posedge clk);
                    #1;
                end
                m_tready = 1'b1;
            end
        join
        drain();

`ifndef AXIS_PKT_MUX_RR_EN
        // rr_mode has no effect without round-robin support.
        rr_mode     = 1'b1;
        sel_in      = 2'd2;
        s_tvalid[1] = 1'b1;
        push_pkt(16'h00D0, 2);
        send_pkt(2, 2, 16'h00D0);
        drain();
        check("rr_ignored_cursel", 32'(cur_sel), 2);
        s_tvalid[1] = 1'b0;
        rr_mode     = 1'b0;
`endif

        // Reset at beat 3 of a 6-beat packet.
        sel_in = 2'd1;
        @(posedge clk);
        #1;
        push_pkt(16'h00F0, 3);
        exp_q[2] = {1'b0, 16'h00F3};
        send_beat(1, 16'h00F1, 1'b0);
        send_beat(1, 16'h00F2, 1'b0);
        send_beat(1, 16'h00F3, 1'b0);
        check("busy_mid_pkt", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("midrst_mvalid", 32'(m_tvalid), 0);
        check("midrst_busy",   32'(busy), 0);
        check("midrst_tready", 32'(s_tready), 0);
        check("midrst_cursel", 32'(cur_sel), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("tready_after_midrst", 32'(s_tready[cur_sel]), 1);
        push_pkt(16'h0070, 6);
        send_pkt(1, 6, 16'h0070);
        drain();
        check("idle_after_pkt", 32'(busy), 0);

        // Out-of-range select on the 3-channel instance.
        for (int i = 0; i < 3; i++) begin
            check("oor_tready", 32'(tready3), 0);
            check("oor_mvalid", 32'(mvalid3), 0);
            @(posedge clk);
            #1;
        end
        sel3 = 2'd1;
        @(posedge clk);
        #1;
        check("inrange_tready", 32'(tready3), 32'h2);
        @(posedge clk);
        #1;
        check("inrange_out", {mvalid3, mdata3}, {1'b1, 16'h2222});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_pkt_mux.md
AXIS_PKT_MUX -- requirements
Module: axis_pkt_mux

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits per channel.
REQ-002 Parameter N_CH, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(N_CH), width of the select and grant fields.
REQ-004 The block SHALL use a single clock and an asynchronous, active-high reset, with ports as follows.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 s_axis_tvalid  in  N_CH  per-channel valid.
REQ-008 s_axis_tready  out  N_CH  per-channel ready.
REQ-009 s_axis_tdata  in  N_CH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
REQ-010 s_axis_tlast  in  N_CH  per-channel end of packet.
REQ-011 sel_in  in  SEL_W  requested channel in fixed mode.
REQ-012 rr_mode  in  1  1 = round-robin arbitration; honoured only with AXIS_PKT_MUX_RR_EN.
REQ-013 m_axis_tdata  out  WIDTH  output data.
REQ-014 m_axis_tvalid  out  1  output valid.
REQ-015 m_axis_tlast  out  1  output end of packet.
REQ-016 m_axis_tready  in  1  downstream ready.
REQ-017 cur_sel  out  SEL_W  current grant register g_q.
REQ-018 busy  out  1  high when state is PKT or the skid buffer is non-empty.

Function
REQ-019 Beat acceptance SHALL be defined as s_axis_tvalid[g_q] & s_axis_tready[g_q].
REQ-020 State machine states:
- IDLE: the grant may change.
- PKT: the grant is frozen.
REQ-021 Transitions out of IDLE:
- IDLE -> PKT on an accepted beat with tlast=0.
- An accepted beat with tlast=1 in IDLE SHALL keep the state IDLE (single-beat packet).
REQ-022 Transitions out of PKT: PKT -> IDLE on an accepted beat with tlast=1; the state SHALL otherwise hold PKT.
REQ-023 In IDLE, fixed mode, g_q SHALL load sel_in every cycle unless IDLE->PKT occurs that cycle; sel-to-grant latency is 1 cycle.
REQ-024 In PKT, changes on sel_in and rr_mode SHALL be ignored, so no packet is ever interleaved with another.
REQ-025 s_axis_tready[g_q] SHALL equal the skid-buffer ready, and every other tready bit SHALL be 0.
REQ-026 s_axis_tready SHALL come from a register and SHALL NOT be combinational from m_axis_tready.
REQ-027 If g_q >= N_CH (out-of-range sel_in), all s_axis_tready SHALL be 0 and no state change occurs.
REQ-028 Output SHALL go through a 2-entry skid buffer:
- 1-cycle latency from accepted beat to m_axis_tvalid.
- 1 beat/cycle sustained while m_axis_tready=1.
REQ-029 Beats SHALL never be dropped or duplicated on m_axis_tready toggling.
REQ-030 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast SHALL be held stable.
REQ-031 Data and tlast SHALL pass unmodified, bit-exact.

Reset
REQ-032 When reset is asserted, the following SHALL apply asynchronously:
- state=IDLE, g_q=0, skid buffer empty.
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
- s_axis_tready=0, busy=0.
REQ-033 Reset mid-packet SHALL discard all buffered beats; no partial packet is completed afterwards.
REQ-034 On the first clock after reset deasserts, s_axis_tready[g_q] SHALL rise.

Configuration
REQ-035 With macro AXIS_PKT_MUX_RR_EN defined and rr_mode=1, in IDLE g_q SHALL load the first channel with tvalid=1, searching ascending from g_q+1 and wrapping N_CH-1 -> 0.
REQ-036 In round-robin mode, g_q SHALL hold if no channel is valid or the current channel is the only valid one.
REQ-037 Without AXIS_PKT_MUX_RR_EN, rr_mode SHALL be ignored, only fixed mode SHALL exist, and no arbitration logic is synthesised.

Structure
REQ-038 Package axis_pkt_mux_pkg SHALL hold:
- the state enum (IDLE, PKT);
- the skid-depth constant (2);
- the round-robin next-grant function.
REQ-039 Sub-module axis_skid_buf (parameter WIDTH+1 for data+tlast) SHALL implement REQ-028 to REQ-030 and be instantiated once.

Verification
REQ-040 Fixed mode: sel_in=2, ch2 sends 4-beat packet 0xA1..0xA4, m_axis_tready=1 -> output 0xA1..0xA4 on consecutive cycles, first 2 cycles after sel_in set, tlast on 0xA4 only.
REQ-041 Switch mid-packet: sel_in changes 1->3 after beat 2 of a 5-beat ch1 packet -> all 5 ch1 beats output, then ch3 granted, cur_sel=3.
REQ-042 Backpressure: m_axis_tready pattern 1,0,0,1,0,1 during an 8-beat packet -> 8 beats in order, no loss or duplicate, data stable while stalled.
REQ-043 Round-robin (macro on, rr_mode=1): ch0, ch1, ch3 each hold 2-beat packets -> output order ch1, ch3, ch0 starting from g_q=0 after reset.
REQ-044 Reset at beat 3 of a 6-beat packet -> m_axis_tvalid=0 immediately, busy=0, state IDLE, next packet passes intact.
REQ-045 Out of range: N_CH=3, sel_in=3 -> all s_axis_tready=0, m_axis_tvalid stays 0.
